// File: rtl/ahb_slave_ctrl_if.sv
// ----------------------------------------------------------------------------
// ahb_slave_ctrl_if
// AHB-Lite bus signals seen by a single slave.
//   HADDR/HTRANS/HWRITE/HSIZE/HSELx/HREADY : address phase, driven by the master side
//   HWDATA                                 : write data, driven by the master side in the data phase
//   HRDATA/HREADYOUT/HRESP                 : slave response
// ----------------------------------------------------------------------------
interface ahb_slave_ctrl_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HSELx;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HSELx, HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HSELx, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_slave_ctrl.sv
// ----------------------------------------------------------------------------
// ahb_slave_ctrl
// AHB-Lite slave transfer controller in front of a four-word register bank.
// Qualifies each address phase, inserts WAIT_STATES wait cycles, answers
// illegal accesses with the two-cycle ERROR response and issues one-cycle
// read/write strobes to the bank in the completing data-phase cycle.
// Ports:
//   clk       : clock, all state on rising edge
//   n_rst     : asynchronous active-low reset
//   bus       : AHB-Lite slave interface (address/data phase, response)
//   reg_idx   : captured word index (HADDR[3:2])
//   reg_wen   : register write strobe
//   reg_ren   : register read strobe
//   reg_wdata : write data to bank (HWDATA pass-through)
//   reg_rdata : read data from bank for reg_idx
// ----------------------------------------------------------------------------
module ahb_slave_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'hF0F0F0F0,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  ahb_slave_ctrl_if.slave   bus,
  output logic [1:0]        reg_idx,
  output logic              reg_wen,
  output logic              reg_ren,
  output logic [31:0]       reg_wdata,
  input  logic [31:0]       reg_rdata
);

  localparam logic [3:0] WAIT_LOAD = WAIT_STATES[3:0];

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } state_t;

  state_t      state_r, next_state_s;
  logic [3:0]  cnt_r, cnt_next_s;
  logic        write_q_r;
  logic        accept_s;
  logic        legal_s;
  logic        unused_s;

  // HTRANS[0] only separates NONSEQ from SEQ, which are handled identically.
  assign unused_s  = bus.HTRANS[0];

  assign accept_s  = bus.HSELx & bus.HREADY & bus.HTRANS[1];
  assign legal_s   = (bus.HADDR[31:4] == BASE_ADDR[31:4]) &&
                     (bus.HSIZE == 3'b010) &&
                     (bus.HADDR[1:0] == 2'b00);
  assign reg_wdata = bus.HWDATA;

  // State, wait counter and captured transfer attributes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      reg_idx   <= 2'd0;
      write_q_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
      if (accept_s) begin
        reg_idx   <= bus.HADDR[3:2];
        write_q_r <= bus.HWRITE;
      end else begin
        reg_idx   <= reg_idx;
        write_q_r <= write_q_r;
      end
    end
  end

  // Next-state and counter logic.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      // IDLE, ACCESS and ERR2 all share the accept rules, giving
      // back-to-back transfers without bubble cycles.
      ST_IDLE, ST_ACCESS, ST_ERR2: begin
        if (accept_s) begin
          if (legal_s) begin
            cnt_next_s   = WAIT_LOAD;
            next_state_s = (WAIT_LOAD != 4'd0) ? ST_WAIT : ST_ACCESS;
          end else begin
            next_state_s = ST_ERR1;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r != 4'd0) begin
          cnt_next_s = cnt_r - 4'd1;
        end else begin
          cnt_next_s = cnt_r;
        end
        // A zero count cannot occur here; treat it like the last wait so
        // the controller can never stall forever.
        if (cnt_r <= 4'd1) begin
          next_state_s = ST_ACCESS;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_ERR1: begin
        next_state_s = ST_ERR2;
      end
      default: begin
        next_state_s = ST_IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // Moore decode of the bus response and bank strobes.
  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = 1'b0;
    bus.HRDATA    = 32'd0;
    reg_wen       = 1'b0;
    reg_ren       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        bus.HREADYOUT = 1'b1;
      end
      ST_WAIT: begin
        bus.HREADYOUT = 1'b0;
      end
      ST_ACCESS: begin
        reg_wen = write_q_r;
        reg_ren = ~write_q_r;
        if (!write_q_r) begin
          bus.HRDATA = reg_rdata;
        end else begin
          bus.HRDATA = 32'd0;
        end
      end
      ST_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = 1'b1;
      end
      ST_ERR2: begin
        bus.HRESP = 1'b1;
      end
      default: begin
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ahb_slave_ctrl
// Scoreboard bench for ahb_slave_ctrl. Three instances (WAIT_STATES 0, 1, 2)
// share one master stimulus; only the instance chosen by dut_sel sees HSELx.
// Stimulus pushes the expected per-cycle response; a monitor on the falling
// edge pops and compares whatever is due in the current cycle.
// ----------------------------------------------------------------------------
module tb_ahb_slave_ctrl;

  logic        clk;
  logic        n_rst;
  int          cyc;
  int          pass_cnt;
  int          total_cnt;

  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hsel;
  logic [31:0] hwdata;
  int          dut_sel;

  logic [31:0] mem [4];

  logic [1:0]  idx0, idx1, idx2;
  logic        wen0, wen1, wen2, ren0, ren1, ren2;
  logic [31:0] wd0, wd1, wd2;

  logic        m_rdy, m_resp, m_wen, m_ren;
  logic [1:0]  m_idx;
  logic [31:0] m_rdata, m_wdata;

  typedef struct {
    int          cyc;
    logic        rdy;
    logic        resp;
    logic        wen;
    logic        ren;
    logic [1:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  ahb_slave_ctrl_if bus0 ();
  ahb_slave_ctrl_if bus1 ();
  ahb_slave_ctrl_if bus2 ();

  assign bus0.HADDR  = haddr;  assign bus1.HADDR  = haddr;  assign bus2.HADDR  = haddr;
  assign bus0.HTRANS = htrans; assign bus1.HTRANS = htrans; assign bus2.HTRANS = htrans;
  assign bus0.HWRITE = hwrite; assign bus1.HWRITE = hwrite; assign bus2.HWRITE = hwrite;
  assign bus0.HSIZE  = hsize;  assign bus1.HSIZE  = hsize;  assign bus2.HSIZE  = hsize;
  assign bus0.HWDATA = hwdata; assign bus1.HWDATA = hwdata; assign bus2.HWDATA = hwdata;
  assign bus0.HSELx  = hsel && (dut_sel == 0);
  assign bus1.HSELx  = hsel && (dut_sel == 1);
  assign bus2.HSELx  = hsel && (dut_sel == 2);
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus1.HREADY = bus1.HREADYOUT;
  assign bus2.HREADY = bus2.HREADYOUT;

  ahb_slave_ctrl #(.BASE_ADDR(32'hF0F0F0F0), .WAIT_STATES(0)) dut0 (
    .clk(clk), .n_rst(n_rst), .bus(bus0.slave), .reg_idx(idx0), .reg_wen(wen0),
    .reg_ren(ren0), .reg_wdata(wd0), .reg_rdata(mem[idx0]));
  ahb_slave_ctrl #(.BASE_ADDR(32'hF0F0F0F0), .WAIT_STATES(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .bus(bus1.slave), .reg_idx(idx1), .reg_wen(wen1),
    .reg_ren(ren1), .reg_wdata(wd1), .reg_rdata(mem[idx1]));
  ahb_slave_ctrl #(.BASE_ADDR(32'hF0F0F0F0), .WAIT_STATES(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .bus(bus2.slave), .reg_idx(idx2), .reg_wen(wen2),
    .reg_ren(ren2), .reg_wdata(wd2), .reg_rdata(mem[idx2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (dut_sel)
      1: begin
        m_rdy = bus1.HREADYOUT; m_resp = bus1.HRESP; m_rdata = bus1.HRDATA;
        m_wen = wen1; m_ren = ren1; m_idx = idx1; m_wdata = wd1;
      end
      2: begin
        m_rdy = bus2.HREADYOUT; m_resp = bus2.HRESP; m_rdata = bus2.HRDATA;
        m_wen = wen2; m_ren = ren2; m_idx = idx2; m_wdata = wd2;
      end
      default: begin
        m_rdy = bus0.HREADYOUT; m_resp = bus0.HRESP; m_rdata = bus0.HRDATA;
        m_wen = wen0; m_ren = ren0; m_idx = idx0; m_wdata = wd0;
      end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, expv);
  endtask

  task automatic push(input int c, input logic rdy, input logic resp, input logic wen,
                      input logic ren, input logic [1:0] idx, input logic [31:0] data);
    exp_t e;
    e.cyc = c; e.rdy = rdy; e.resp = resp; e.wen = wen; e.ren = ren; e.idx = idx; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int c);
    push(c, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic w,
                       input logic [2:0] s, input logic sel, input logic [31:0] wd);
    haddr = a; htrans = t; hwrite = w; hsize = s; hsel = sel; hwdata = wd;
  endtask

  task automatic drive_idle();
    drive(32'd0, 2'b00, 1'b0, 3'b010, 1'b0, hwdata);
  endtask

  // Monitor: compare every expectation due this cycle and flag unexpected strobes.
  always @(negedge clk) begin
    bit matched;
    matched = 1'b0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        exp_t e;
        e = exp_q[i];
        matched = 1'b1;
        chk("hreadyout", {31'd0, m_rdy}, {31'd0, e.rdy});
        chk("hresp", {31'd0, m_resp}, {31'd0, e.resp});
        chk("reg_wen", {31'd0, m_wen}, {31'd0, e.wen});
        chk("reg_ren", {31'd0, m_ren}, {31'd0, e.ren});
        if (e.wen || e.ren) chk("reg_idx", {30'd0, m_idx}, {30'd0, e.idx});
        if (e.wen) chk("reg_wdata", m_wdata, e.data);
        if (e.ren) chk("hrdata", m_rdata, e.data);
        else chk("hrdata_zero", m_rdata, 32'd0);
        exp_q.delete(i);
      end
    end
    if (!matched && (m_wen || m_ren)) begin
      total_cnt++;
      $display("FAIL spurious_strobe cycle %0d: got wen=%b ren=%b, expected none", cyc, m_wen, m_ren);
    end
  end

  initial begin
    int t;
    cyc = 0; pass_cnt = 0; total_cnt = 0;
    mem[0] = 32'h0BADF00D; mem[1] = 32'h12345678; mem[2] = 32'hCAFEF00D; mem[3] = 32'h55AA55AA;
    n_rst = 1'b0; dut_sel = 0; hwdata = 32'd0;
    drive_idle();

    // Reset state, then release with an idle bus.
    step(); push_idle(cyc);
    step(); n_rst = 1'b1; push_idle(cyc);
    step(); push_idle(cyc);

    // Write, zero wait states.
    dut_sel = 0;
    step(); drive(32'hF0F0F0F8, 2'b10, 1'b1, 3'b010, 1'b1, 32'd0); t = cyc;
    push_idle(t);
    push(t + 1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'hDEADBEEF);
    step(); drive_idle(); hwdata = 32'hDEADBEEF;
    step(); push_idle(cyc);

    // Non-accepts: BUSY while selected, NONSEQ while deselected.
    step(); drive(32'hF0F0F0F4, 2'b01, 1'b1, 3'b010, 1'b1, 32'd0); push_idle(cyc + 1);
    step(); drive(32'hF0F0F0F4, 2'b10, 1'b1, 3'b010, 1'b0, 32'd0); push_idle(cyc + 1);
    step(); drive_idle();

    // Read, two wait states.
    dut_sel = 2;
    step(); drive(32'hF0F0F0F4, 2'b10, 1'b0, 3'b010, 1'b1, 32'd0); t = cyc;
    push(t + 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    push(t + 2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    push(t + 3, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'h12345678);
    push_idle(t + 4);
    step(); drive_idle();
    step(); step(); step();

    // Errors: misaligned, wrong size (accepted in ERR2), outside the window.
    dut_sel = 1;
    step(); drive(32'hF0F0F0F2, 2'b10, 1'b0, 3'b010, 1'b1, 32'd0); t = cyc;
    push(t + 1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    push(t + 2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    step(); drive_idle();
    step(); drive(32'hF0F0F0F4, 2'b10, 1'b1, 3'b001, 1'b1, 32'd0);
    push(t + 3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    push(t + 4, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    step(); drive_idle();
    step(); drive(32'hF0F0F100, 2'b10, 1'b0, 3'b010, 1'b1, 32'd0);
    push(t + 5, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    push(t + 6, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    step(); drive_idle();
    step(); push_idle(t + 7);
    step();

    // Pipelined write then SEQ read, one wait state.
    step(); drive(32'hF0F0F0F0, 2'b10, 1'b1, 3'b010, 1'b1, 32'd0); t = cyc;
    push(t + 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    push(t + 2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'hA5A50001);
    push(t + 3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    push(t + 4, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'h12345678);
    push_idle(t + 5);
    step(); drive(32'hF0F0F0F4, 2'b11, 1'b0, 3'b010, 1'b1, 32'hA5A50001);
    step();
    step(); drive_idle();
    step(); step();

    // Reset asserted mid-WAIT: response returns to idle at once, no strobe later.
    dut_sel = 2;
    step(); drive(32'hF0F0F0F0, 2'b10, 1'b0, 3'b010, 1'b1, 32'd0); t = cyc;
    step(); n_rst = 1'b0; drive_idle(); push_idle(t + 1);
    step(); push_idle(t + 2);
    step(); n_rst = 1'b1; push_idle(t + 3);
    step(); push_idle(t + 4);
    step(); step();

    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ahb_slave_ctrl.md
# ahb_slave_ctrl

AHB-Lite slave-side transfer controller. It sits between the system AHB bus and a four-word memory-mapped register bank. It decodes and qualifies each address phase, inserts a programmable number of wait states, and returns the two-cycle ERROR response for illegal accesses. It issues single-cycle read/write strobes to the register bank during the completing data-phase cycle.

## Interface

Parameters:
- BASE_ADDR, 32'hF0F0F0F0, word-aligned base of the 16-byte register window (BASE_ADDR[3:0] must be 0).
- WAIT_STATES, 1, wait cycles inserted per valid transfer; legal range 0..15.

Ports:
- clk  in  1  system clock, all state on rising edge
- n_rst  in  1  asynchronous, active-low reset
- HADDR  in  32  address phase address
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWRITE  in  1  high = write, low = read
- HSIZE  in  3  transfer size; only 3'b010 (word) is legal
- HSELx  in  1  slave select
- HREADY  in  1  bus-wide ready (previous transfer completing)
- HWDATA  in  32  write data, valid in data phase
- HRDATA  out  32  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 OKAY, 1 ERROR
- reg_idx  out  2  captured word index (HADDR[3:2])
- reg_wen  out  1  register write strobe
- reg_ren  out  1  register read strobe
- reg_wdata  out  32  write data to bank (= HWDATA)
- reg_rdata  in  32  read data from bank for reg_idx

## Operation

- Accept condition (address phase): HSELx & HREADY & HTRANS[1]. In the accept cycle, capture HADDR[3:2]→reg_idx, HWRITE→write_q, and the legality flag.
- Legal: HADDR[31:4] == BASE_ADDR[31:4], HSIZE == 3'b010, HADDR[1:0] == 0.
- HTRANS IDLE/BUSY, or HSELx low, is not an accept. It causes no transfer, no strobes, and no state change out of IDLE.
- States:
  - IDLE: HREADYOUT=1, HRESP=0. On a legal accept → WAIT (load counter = WAIT_STATES) if WAIT_STATES>0, else → ACCESS. On an illegal accept → ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle. When counter == 1 → ACCESS. Accepts are impossible here because HREADY is low.
  - ACCESS: HREADYOUT=1, HRESP=0. reg_wen=write_q, reg_ren=~write_q. HRDATA=reg_rdata when reading. Next state uses IDLE accept rules, which gives pipelined back-to-back transfers. With no accept → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2 unconditionally.
  - ERR2: HREADYOUT=1, HRESP=1. Next state uses IDLE accept rules. The master may cancel, giving HTRANS=IDLE → IDLE.
- HRDATA is 0 in every state other than ACCESS with write_q=0.
- reg_wdata is HWDATA passed through combinationally. The bank samples it only when reg_wen=1.
- HREADYOUT and HRESP are Moore decodes of the registered state.
- Counter is 4 bits and never wraps. It is reloaded on every legal accept.
- Reset (async, any state, including mid-WAIT or mid-ERR):
  - state=IDLE, counter=0, reg_idx=0, write_q=0.
  - HREADYOUT=1, HRESP=0, reg_wen=0, reg_ren=0, HRDATA=0.
  - An interrupted transfer produces no strobe.

## Timing

- Accept at cycle t; WAIT_STATES = W:
  - cycles t+1 .. t+W: HREADYOUT=0.
  - cycle t+1+W: ACCESS, HREADYOUT=1, one-cycle strobe.
- W=0: ACCESS at t+1, zero-wait.
- Error: ERR1 at t+1, ERR2 at t+2. Strobes stay 0 throughout.
- Back-to-back: a new accept in ACCESS or ERR2 (cycle c) starts the next transfer at c+1. There are no bubble cycles.
- Strobe count: exactly one reg_wen or reg_ren pulse per legal accept, and none for illegal accepts.
- Read data path from reg_idx to HRDATA is combinational within the ACCESS cycle.

## Test plan

- Reset: hold n_rst=0 mid-WAIT → HREADYOUT=1, HRESP=0, strobes 0 immediately. After release, idle bus → stays IDLE, no strobes.
- Write, W=0: accept HADDR=F0F0F0F8, HWRITE=1, HSIZE=010; HWDATA=DEADBEEF next cycle.
  - Required: at t+1, reg_wen=1, reg_idx=2, reg_wdata=DEADBEEF, HREADYOUT=1.
- Read, W=2: accept HADDR=F0F0F0F4, read; reg_rdata=12345678.
  - Required: HREADYOUT=0 at t+1 and t+2. At t+3, HREADYOUT=1, reg_ren=1, HRDATA=12345678.
- Errors: each of HADDR=F0F0F0F2, HSIZE=001, and HADDR=F0F0F100.
  - Required: HREADYOUT=0/HRESP=1 at t+1, then HREADYOUT=1/HRESP=1 at t+2. No strobes.
- Pipelined, W=1: NONSEQ write idx0, then SEQ read idx1 accepted in the write's ACCESS cycle, then an HTRANS=IDLE beat.
  - Required: reg_wen at t+2, reg_ren at t+4, then IDLE.
- Non-accepts: HTRANS=BUSY with HSELx=1, and NONSEQ with HSELx=0 → no state change, HREADYOUT=1, HRESP=0, no strobes.
